// File: rtl/i2s_tx_if.sv
// Sample handshake between the last filter stage and the I2S transmitter.
// The filter stage drives a stereo pair plus valid. The transmitter answers
// with ready while its single-entry holding register is empty.
interface i2s_tx_if;
   logic [15:0] left_in;
   logic [15:0] right_in;
   logic        sample_valid;
   logic        sample_ready;

   modport master (
      output left_in,
      output right_in,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  left_in,
      input  right_in,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/i2s_tx.sv
// Philips-I2S transmitter, bus master. BCLK is divided down from clk. Each
// frame carries one signed 16-bit stereo pair, MSB first, one BCLK after the
// LRCLK edge, and the rest of each slot is zero padding. If no new pair is
// waiting when a frame loads, silence is sent and underrun pulses for one clk.
module i2s_tx #(
   parameter int CLK_DIV = 4,
   parameter int SLOT_W  = 32
) (
   input  logic     clk,
   input  logic     reset_n,
   i2s_tx_if.slave  samples,
   output logic     bclk,
   output logic     lrclk,
   output logic     sdata,
   output logic     underrun
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int B_W   = $clog2(2 * SLOT_W);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_W - 1);
   localparam logic [B_W-1:0]   LR_FIRST = B_W'(SLOT_W - 1);
   localparam logic [B_W-1:0]   LR_LAST  = B_W'(2 * SLOT_W - 2);
   localparam logic [B_W-1:0]   L_LAST   = B_W'(15);
   localparam logic [B_W-1:0]   R_FIRST  = B_W'(SLOT_W);
   localparam logic [B_W-1:0]   R_LAST   = B_W'(SLOT_W + 15);

   logic [DIV_W-1:0] div_cnt;
   logic [B_W-1:0]   b;
   logic [B_W-1:0]   b_next;
   logic             tick;
   logic             fall_evt;
   logic             load;
   logic             accept;
   logic             pending;
   logic [15:0]      hold_l;
   logic [15:0]      hold_r;
   logic [15:0]      frame_l;
   logic [15:0]      frame_r;
   logic             lrclk_next;
   logic             sdata_next;
   logic [3:0]       l_idx;
   logic [3:0]       r_idx;

   assign samples.sample_ready = ~pending;

   // Event decode: BCLK toggles at divider terminal count, a toggle from high
   // is a falling event, and the falling event that wraps the bit position to
   // the last slot position is where the next frame is loaded.
   always_comb begin
      tick     = (div_cnt == DIV_LAST);
      fall_evt = tick && bclk;
      b_next   = (b == B_LAST) ? '0 : b + B_W'(1);
      load     = fall_evt && (b_next == B_LAST);
      accept   = samples.sample_valid && !pending;
   end

   // Next serial bit and word select for the upcoming bit position. The frame
   // registers are still the old frame here, which matters when the right
   // LSB sits on the load position (SLOT_W of 16).
   always_comb begin
      l_idx      = ~4'(b_next);
      r_idx      = ~4'(b_next - R_FIRST);
      lrclk_next = (b_next >= LR_FIRST) && (b_next <= LR_LAST);
      sdata_next = 1'b0;
      if (b_next <= L_LAST) begin
         sdata_next = frame_l[l_idx];
      end else if ((b_next >= R_FIRST) && (b_next <= R_LAST)) begin
         sdata_next = frame_r[r_idx];
      end
   end

   // Clock divider generating BCLK.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Bit position and serial outputs advance only on BCLK falling events so
   // the DAC sees stable data around every rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         b     <= B_LAST;
         lrclk <= 1'b0;
         sdata <= 1'b0;
      end else if (fall_evt) begin
         b     <= b_next;
         lrclk <= lrclk_next;
         sdata <= sdata_next;
      end
   end

   // Single-entry holding register; a load with an empty holder leaves it
   // free so a pair accepted in that same cycle is kept for the next frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= 1'b0;
         hold_l  <= '0;
         hold_r  <= '0;
      end else begin
         if (accept) begin
            hold_l <= samples.left_in;
            hold_r <= samples.right_in;
         end
         if (load && pending) begin
            pending <= 1'b0;
         end else if (accept) begin
            pending <= 1'b1;
         end
      end
   end

   // Frame load: take the waiting pair, or fall back to silence and flag it.
   // A stale pair is never replayed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_l  <= '0;
         frame_r  <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= load && !pending;
         if (load) begin
            frame_l <= pending ? hold_l : 16'h0000;
            frame_r <= pending ? hold_r : 16'h0000;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx. Two instances are exercised one after the
// other: the default parameters and the minimum CLK_DIV=1 / SLOT_W=16 build.
// The reference model derives every output from the clk edge count since
// reset and from a per-frame table of the words that should be on the wire.
module tb_i2s_tx;

   logic clk;
   logic reset_def_n;
   logic reset_min_n;
   logic use_min;

   logic [15:0] left_drv;
   logic [15:0] right_drv;
   logic        valid_drv;

   logic bclk_d, lrclk_d, sdata_d, underrun_d;
   logic bclk_m, lrclk_m, sdata_m, underrun_m;
   logic obs_bclk, obs_lrclk, obs_sdata, obs_underrun, obs_ready;

   i2s_tx_if bus_d ();
   i2s_tx_if bus_m ();

   assign bus_d.left_in      = left_drv;
   assign bus_d.right_in     = right_drv;
   assign bus_d.sample_valid = valid_drv;
   assign bus_m.left_in      = left_drv;
   assign bus_m.right_in     = right_drv;
   assign bus_m.sample_valid = valid_drv;

   i2s_tx #(.CLK_DIV(4), .SLOT_W(32)) dut (
      .clk      (clk),
      .reset_n  (reset_def_n),
      .samples  (bus_d),
      .bclk     (bclk_d),
      .lrclk    (lrclk_d),
      .sdata    (sdata_d),
      .underrun (underrun_d)
   );

   i2s_tx #(.CLK_DIV(1), .SLOT_W(16)) dut_min (
      .clk      (clk),
      .reset_n  (reset_min_n),
      .samples  (bus_m),
      .bclk     (bclk_m),
      .lrclk    (lrclk_m),
      .sdata    (sdata_m),
      .underrun (underrun_m)
   );

   // Route whichever instance is under test to the checker.
   always_comb begin
      obs_bclk     = use_min ? bclk_m     : bclk_d;
      obs_lrclk    = use_min ? lrclk_m    : lrclk_d;
      obs_sdata    = use_min ? sdata_m    : sdata_d;
      obs_underrun = use_min ? underrun_m : underrun_d;
      obs_ready    = use_min ? bus_m.sample_ready : bus_d.sample_ready;
   end

   // Free-running system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   int cd;
   int sw;
   int cyc;
   bit m_pend;
   bit m_ur;
   bit m_acc;
   logic [15:0] m_hl;
   logic [15:0] m_hr;
   logic [15:0] fl [int];
   logic [15:0] frr [int];

   function automatic int frameLen();
      return 4 * cd * sw;
   endfunction

   function automatic int curB();
      int m;
      m = cyc / (2 * cd);
      if (m == 0) return 2 * sw - 1;
      return (m - 1) % (2 * sw);
   endfunction

   task automatic modelReset();
      cyc    = 0;
      m_pend = 1'b0;
      m_ur   = 1'b0;
      m_acc  = 1'b0;
      m_hl   = '0;
      m_hr   = '0;
      fl.delete();
      frr.delete();
      fl[0]  = '0;
      frr[0] = '0;
   endtask

   task automatic modelEdge(input logic v, input logic [15:0] l, input logic [15:0] r);
      bit old_p;
      int j;
      old_p = m_pend;
      m_ur  = 1'b0;
      m_acc = 1'b0;
      if (cyc % frameLen() == 0) begin
         j = cyc / frameLen();
         if (m_pend) begin
            fl[j]  = m_hl;
            frr[j] = m_hr;
            m_pend = 1'b0;
         end else begin
            fl[j]  = '0;
            frr[j] = '0;
            m_ur   = 1'b1;
         end
      end
      if (v && !old_p) begin
         m_hl   = l;
         m_hr   = r;
         m_pend = 1'b1;
         m_acc  = 1'b1;
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic checkOutput();
      int m;
      int b;
      int f;
      logic [15:0] w;
      logic e_bclk, e_lr, e_sd;
      e_bclk = ((cyc / cd) % 2) == 1;
      m = cyc / (2 * cd);
      b = curB();
      f = (m == 0) ? -1 : (m - 1) / (2 * sw);
      e_lr = (b >= sw - 1) && (b <= 2 * sw - 2);
      e_sd = 1'b0;
      if (f >= 0) begin
         if (b < 16) begin
            w = fl[f];
            e_sd = w[15 - b];
         end else if (b >= sw && b < sw + 16) begin
            w = frr[f];
            e_sd = w[15 - (b - sw)];
         end
      end
      checkBit("bclk", obs_bclk, e_bclk);
      checkBit("lrclk", obs_lrclk, e_lr);
      checkBit("sdata", obs_sdata, e_sd);
      checkBit("underrun", obs_underrun, m_ur);
      checkBit("sample_ready", obs_ready, !m_pend);
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] l, input logic [15:0] r);
      valid_drv = v;
      left_drv  = l;
      right_drv = r;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      cyc++;
      modelEdge(valid_drv, left_drv, right_drv);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic runTo(input int target);
      while (cyc < target) stepCycle();
   endtask

   task automatic sendPair(input logic [15:0] l, input logic [15:0] r, input int budget);
      applyStimulus(1'b1, l, r);
      for (int i = 0; i < budget; i++) begin
         stepCycle();
         if (m_acc) break;
      end
      applyStimulus(1'b0, 16'h0000, 16'h0000);
   endtask

   task automatic runUntilB(input int target);
      for (int i = 0; i < 2 * frameLen(); i++) begin
         if (curB() == target) break;
         stepCycle();
      end
   endtask

   // Asserted away from a clock edge so the asynchronous clear is visible
   // before any edge arrives; released on a falling clk edge.
   task automatic pulseReset(input int ncyc);
      if (use_min) reset_min_n = 1'b0;
      else         reset_def_n = 1'b0;
      modelReset();
      #1;
      checkOutput();
      repeat (ncyc) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput();
      end
      if (use_min) reset_min_n = 1'b1;
      else         reset_def_n = 1'b1;
      #1;
      checkOutput();
   endtask

   // Directed sequence with randomized data and timing.
   initial begin
      total = 0;
      bad   = 0;
      use_min     = 1'b0;
      reset_def_n = 1'b0;
      reset_min_n = 1'b0;
      cd = 4;
      sw = 32;
      applyStimulus(1'b0, 16'h0000, 16'h0000);
      modelReset();
      @(negedge clk);

      $display("[TB] power-on reset and silent first frame");
      pulseReset(3);
      runTo(frameLen() + 8);

      $display("[TB] single pair A5C3/8001");
      runTo(frameLen() + 30);
      sendPair(16'hA5C3, 16'h8001, 600);
      runTo(3 * frameLen() + 4);

      $display("[TB] backpressure with two held pairs");
      sendPair(16'h1234, 16'h5678, 600);
      sendPair(16'h7FFF, 16'hFFFF, 600);
      $display("[TB] underrun frame after valid data");
      runTo(((cyc / frameLen()) + 3) * frameLen() + 4);

      $display("[TB] randomized pairs");
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 3) != 0) begin
            runTo(cyc + $urandom_range(0, frameLen() - 40));
            sendPair(16'($urandom), 16'($urandom), 600);
         end
         runTo(((cyc / frameLen()) + 1) * frameLen() + 3);
      end

      $display("[TB] reset in the middle of the right slot");
      runTo(cyc + 20);
      sendPair(16'($urandom), 16'($urandom), 600);
      runUntilB(sw + 20);
      pulseReset(3);
      runTo(2 * frameLen() + 8);

      $display("[TB] minimum parameters");
      reset_def_n = 1'b0;
      use_min = 1'b1;
      cd = 1;
      sw = 16;
      pulseReset(3);
      runTo(10);
      sendPair(16'h0001, 16'($urandom), 60);
      runTo(2 * frameLen() + 2);
      for (int k = 0; k < 3; k++) begin
         runTo(cyc + $urandom_range(0, frameLen() - 10));
         sendPair(16'($urandom), 16'($urandom), 60);
         runTo(((cyc / frameLen()) + 2) * frameLen() + 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
